lsd_buffer_reader: RTL and testbench
====================================

// Module: lsd_buffer_reader
// PURPOSE
//  Readout sequencer for the write-protected LSD line-segment buffer, on the PS-side clock.
//  On a start request it locks the buffer (write protect) and waits until the buffer is ready.
//  It then walks read addresses 0..line_num-1, returns each segment as a valid/ready stream
//  beat for the DMA/PS path, and releases the lock when the frame is drained.
// PARAMETERS
//  FRAME_HEIGHT  1024  frame lines incl. blanking; VW = $clog2(FRAME_HEIGHT)
//  FRAME_WIDTH   2048  frame pixels incl. blanking; HW = $clog2(FRAME_WIDTH)
//  RAM_SIZE      4096  buffer depth in segments; AW = $clog2(RAM_SIZE)
//  RD_LATENCY    2     cycles from out_rd_addr change to valid in_seg_* data (>=1)
// PORTS
//  clock              in   1          readout clock (psclk domain)
//  n_rst              in   1          asynchronous reset, active low
//  in_start           in   1          1-cycle request: read out the current frame's segments
//  in_buf_ready       in   1          buffer holds a complete, stable frame under protect
//  in_line_num        in   AW         number of valid segments in buffer
//  in_seg_start_v     in   VW         segment start row at out_rd_addr
//  in_seg_end_v       in   VW         segment end row
//  in_seg_start_h     in   HW         segment start column
//  in_seg_end_h       in   HW         segment end column
//  out_rd_addr        out  AW         buffer read address
//  out_write_protect  out  1          freezes buffer writes while high
//  out_tdata          out  2*(VW+HW)  {start_v,start_h,end_v,end_h}, MSB first
//  out_tvalid         out  1          stream beat valid
//  in_tready          in   1          downstream accepts beat
//  out_tlast          out  1          high on the final beat of a frame
//  out_busy           out  1          high in any state other than IDLE
//  out_done           out  1          1-cycle pulse on readout completion
//  out_seg_count      out  AW         segments emitted in the last/current readout
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - State goes to IDLE.
//   - All outputs are 0 (out_rd_addr, out_write_protect, out_tdata, out_tvalid, out_tlast,
//     out_busy, out_done, out_seg_count).
//   - Reset mid-readout drops out_write_protect and out_tvalid immediately. No done pulse.
//  FSM states:
//   - IDLE:
//     - in_start=1 -> LOCK. Set out_write_protect=1 and out_seg_count=0 on the next cycle.
//   - LOCK:
//     - Hold protect. Wait for in_buf_ready=1.
//     - On ready, latch N=in_line_num.
//     - If N=0, go to FIN.
//     - Otherwise set out_rd_addr=0 and go to WAIT.
//   - WAIT:
//     - Count RD_LATENCY cycles after the address is set.
//     - On the last count, register in_seg_* into out_tdata, set out_tvalid=1, go to SEND.
//     - Set out_tlast=1 when out_rd_addr==N-1.
//   - SEND:
//     - Hold out_tdata, out_tvalid and out_tlast stable until in_tready=1 (AXI-S rule:
//       never drop valid before the handshake).
//     - On handshake: out_seg_count += 1.
//     - If the beat was last: clear valid and go to FIN.
//     - Otherwise clear valid, out_rd_addr += 1, and go to WAIT.
//   - FIN:
//     - 1 cycle. out_done=1, out_write_protect=0, go to IDLE.
//  Timing and throughput:
//   - The first beat appears RD_LATENCY+1 cycles after ready is seen in LOCK.
//   - Maximum throughput is 1 beat per RD_LATENCY+1 cycles with tready held high.
//   - There is no bubble-free pipelining by design.
//  Address and count widths:
//   - N is taken as-is at AW bits.
//   - out_rd_addr never exceeds N-1 and never wraps.
//   - out_seg_count ends equal to N.
//  Simultaneous and late events:
//   - in_start while busy is ignored (not queued).
//   - in_start in the FIN cycle is also ignored.
//   - in_line_num or in_buf_ready changes after the LOCK latch are ignored until IDLE.
//   - in_tready high with out_tvalid low has no effect.
//   - in_buf_ready may never rise; the FSM then stays in LOCK. Software recovers via n_rst.
//  out_busy = (state != IDLE), driven from registered state.
// TESTING
//  1. Reset mid-SEND, N=8 at beat 3 -> next cycle protect=0, tvalid=0, busy=0, no done.
//  2. N=3, RD_LATENCY=2, tready=1, ready high at LOCK ->
//     - beats carry addr 0,1,2, one beat every 3 cycles
//     - tlast only on beat 2
//     - done 1 cycle after beat 2; seg_count=3
//  3. N=0 -> no tvalid ever; done 2 cycles after ready; protect high exactly during LOCK..FIN.
//  4. N=4, tready toggled randomly (stall up to 10 cycles) ->
//     - tdata/tlast stable while valid && !tready
//     - 4 beats exactly, addr 0..3 in order
//  5. ready held low 50 cycles, then high, in_start pulsed again meanwhile ->
//     - single readout
//     - protect high throughout
//     - second start ignored
//  6. N=RAM_SIZE-1 (4095) with tready=1 ->
//     - final addr 4094 with tlast=1
//     - seg_count=4095; no address wrap

Source files
------------

// File: rtl/lsd_buffer_reader.sv
// Readout sequencer for the write-protected LSD segment buffer: locks the buffer,
// walks addresses 0..N-1 and emits each segment as one valid/ready stream beat.
module lsd_buffer_reader #(
    parameter int FRAME_HEIGHT = 1024,
    parameter int FRAME_WIDTH  = 2048,
    parameter int RAM_SIZE     = 4096,
    parameter int RD_LATENCY   = 2,
    localparam int VW = $clog2(FRAME_HEIGHT),
    localparam int HW = $clog2(FRAME_WIDTH),
    localparam int AW = $clog2(RAM_SIZE),
    localparam int DW = 2 * (VW + HW)
) (
    input  logic          clock,
    input  logic          n_rst,
    input  logic          in_start,
    input  logic          in_buf_ready,
    input  logic [AW-1:0] in_line_num,
    input  logic [VW-1:0] in_seg_start_v,
    input  logic [VW-1:0] in_seg_end_v,
    input  logic [HW-1:0] in_seg_start_h,
    input  logic [HW-1:0] in_seg_end_h,
    output logic [AW-1:0] out_rd_addr,
    output logic          out_write_protect,
    output logic [DW-1:0] out_tdata,
    output logic          out_tvalid,
    input  logic          in_tready,
    output logic          out_tlast,
    output logic          out_busy,
    output logic          out_done,
    output logic [AW-1:0] out_seg_count
);

    localparam int LW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_WAIT,
        ST_SEND,
        ST_FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] line_n;
    logic [LW-1:0] wait_cnt;
    logic          wait_done;

    assign wait_done = (wait_cnt == LW'(RD_LATENCY - 1));
    assign out_busy  = (state != ST_IDLE);

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In SEND the beat is always valid, so tready alone marks the handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_start) begin
                    state_next = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (in_buf_ready) begin
                    state_next = (in_line_num == '0) ? ST_FIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (in_tready) begin
                    state_next = out_tlast ? ST_FIN : ST_WAIT;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Done is registered so it is high exactly for the single FIN cycle.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_rd_addr       <= '0;
            out_write_protect <= 1'b0;
            out_tdata         <= '0;
            out_tvalid        <= 1'b0;
            out_tlast         <= 1'b0;
            out_done          <= 1'b0;
            out_seg_count     <= '0;
            line_n            <= '0;
            wait_cnt          <= '0;
        end else begin
            out_done <= (state_next == ST_FIN);
            case (state)
                ST_IDLE: begin
                    if (in_start) begin
                        out_write_protect <= 1'b1;
                        out_seg_count     <= '0;
                    end
                end
                ST_LOCK: begin
                    if (in_buf_ready) begin
                        line_n      <= in_line_num;
                        out_rd_addr <= '0;
                        wait_cnt    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        out_tdata  <= {in_seg_start_v, in_seg_start_h, in_seg_end_v, in_seg_end_h};
                        out_tvalid <= 1'b1;
                        out_tlast  <= (out_rd_addr == line_n - AW'(1));
                    end else begin
                        wait_cnt <= wait_cnt + LW'(1);
                    end
                end
                ST_SEND: begin
                    if (in_tready) begin
                        out_seg_count <= out_seg_count + AW'(1);
                        out_tvalid    <= 1'b0;
                        out_tlast     <= 1'b0;
                        if (!out_tlast) begin
                            out_rd_addr <= out_rd_addr + AW'(1);
                            wait_cnt    <= '0;
                        end
                    end
                end
                ST_FIN: begin
                    out_write_protect <= 1'b0;
                end
                default: begin
                    out_write_protect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsd_buffer_reader.sv
// Directed bench for lsd_buffer_reader: a registered buffer model feeds segment data and a
// queue of expected beats is filled at each start and drained on every stream handshake.
module tb_lsd_buffer_reader;

    localparam int VW = 10;
    localparam int HW = 11;
    localparam int AW = 12;
    localparam int DW = 2 * (VW + HW);

    logic          clock = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_start = 1'b0;
    logic          in_buf_ready = 1'b0;
    logic [AW-1:0] in_line_num = '0;
    logic [VW-1:0] in_seg_start_v;
    logic [VW-1:0] in_seg_end_v;
    logic [HW-1:0] in_seg_start_h;
    logic [HW-1:0] in_seg_end_h;
    logic [AW-1:0] out_rd_addr;
    logic          out_write_protect;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          in_tready = 1'b0;
    logic          out_tlast;
    logic          out_busy;
    logic          out_done;
    logic [AW-1:0] out_seg_count;

    lsd_buffer_reader #(
        .FRAME_HEIGHT(1024),
        .FRAME_WIDTH (2048),
        .RAM_SIZE    (4096),
        .RD_LATENCY  (2)
    ) dut (
        .clock            (clock),
        .n_rst            (n_rst),
        .in_start         (in_start),
        .in_buf_ready     (in_buf_ready),
        .in_line_num      (in_line_num),
        .in_seg_start_v   (in_seg_start_v),
        .in_seg_end_v     (in_seg_end_v),
        .in_seg_start_h   (in_seg_start_h),
        .in_seg_end_h     (in_seg_end_h),
        .out_rd_addr      (out_rd_addr),
        .out_write_protect(out_write_protect),
        .out_tdata        (out_tdata),
        .out_tvalid       (out_tvalid),
        .in_tready        (in_tready),
        .out_tlast        (out_tlast),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_seg_count    (out_seg_count)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] seg_of(input logic [AW-1:0] a);
        logic [VW-1:0] sv;
        logic [VW-1:0] ev;
        logic [HW-1:0] sh;
        logic [HW-1:0] eh;
        sv = a[VW-1:0] ^ 10'h155;
        sh = a[HW-1:0] + 11'd300;
        ev = a[VW-1:0] + 10'd17;
        eh = {a[AW-1], a[VW-1:0]} ^ 11'h5A5;
        return {sv, sh, ev, eh};
    endfunction

    // Buffer model with a two-cycle read: data for an address is valid two edges later.
    logic [AW-1:0] addr_d;
    always @(posedge clock or negedge n_rst) begin
        if (!n_rst) addr_d <= '0;
        else        addr_d <= out_rd_addr;
    end
    assign {in_seg_start_v, in_seg_start_h, in_seg_end_v, in_seg_end_h} = seg_of(addr_d);

    int            passed = 0;
    int            total = 0;
    int            cyc = 0;
    int            beat_count = 0;
    int            done_count = 0;
    int            done_cyc = 0;
    int            valid_seen = 0;
    logic [AW-1:0] done_seg = '0;
    logic [AW-1:0] max_addr = '0;
    logic          stall_chk = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_tdata = '0;
    logic          prev_tlast = 1'b0;
    logic [DW:0]   sb[$];
    int            beat_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i == n - 1), seg_of(AW'(i))});
        end
    endtask

    // Samples the current cycle (#1 after the edge), then advances one clock.
    task automatic tick();
        logic [DW:0] e;
        if (stall_chk && prev_stall) begin
            check("stall_tvalid", out_tvalid, 1'b1);
            check("stall_tdata", out_tdata, prev_tdata);
            check("stall_tlast", out_tlast, prev_tlast);
        end
        if (out_tvalid && in_tready) begin
            if (sb.size() == 0) begin
                check("extra_beat", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("beat_tdata", out_tdata, e[DW-1:0]);
                check("beat_tlast", out_tlast, e[DW]);
            end
            beat_cyc.push_back(cyc);
            beat_count++;
        end
        if (out_done) begin
            done_count++;
            done_cyc = cyc;
            done_seg = out_seg_count;
        end
        if (out_tvalid) valid_seen++;
        if (out_rd_addr > max_addr) max_addr = out_rd_addr;
        prev_stall = out_tvalid && !in_tready;
        prev_tdata = out_tdata;
        prev_tlast = out_tlast;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int budget, input int d0);
        int n;
        n = 0;
        while (done_count == d0 && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", (done_count == d0 + 1), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int cs;
        int d0;
        int bc0;
        int vs;
        int n;
        int stall;
        int prot_drop;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_rd_addr", out_rd_addr, 0);
        check("rst_protect", out_write_protect, 0);
        check("rst_tdata", out_tdata, 0);
        check("rst_tvalid", out_tvalid, 0);
        check("rst_tlast", out_tlast, 0);
        check("rst_busy", out_busy, 0);
        check("rst_done", out_done, 0);
        check("rst_seg_count", out_seg_count, 0);
        n_rst = 1'b1;
        tick();
        tick();

        // N=3, tready high: beat cadence, tlast, done timing, late line_num/ready changes, start in FIN
        $display("[TB] N=3 streaming readout");
        push_frame(3);
        beat_cyc.delete();
        in_line_num = 12'd3;
        in_buf_ready = 1'b1;
        in_tready = 1'b1;
        in_start = 1'b1;
        cs = cyc;
        d0 = done_count;
        tick();
        in_start = 1'b0;
        check("t2_protect_lock", out_write_protect, 1'b1);
        tick();
        in_line_num = 12'd7;
        in_buf_ready = 1'b0;
        n = 0;
        while (done_count == d0 && n < 100) begin
            in_start = (cyc == cs + 11);
            tick();
            n++;
        end
        in_start = 1'b0;
        check("t2_done_reached", (done_count == d0 + 1), 1'b1);
        check("t2_beats", beat_cyc.size(), 3);
        if (beat_cyc.size() == 3) begin
            check("t2_beat0_cyc", beat_cyc[0] - cs, 4);
            check("t2_beat1_cyc", beat_cyc[1] - cs, 7);
            check("t2_beat2_cyc", beat_cyc[2] - cs, 10);
        end
        check("t2_done_cyc", done_cyc - cs, 11);
        check("t2_seg_count", done_seg, 3);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_fin_start_busy", out_busy, 1'b0);
        check("t2_protect_off", out_write_protect, 1'b0);
        tick();
        check("t2_idle_busy", out_busy, 1'b0);

        // N=0: no beats, protect covers LOCK and FIN only
        $display("[TB] N=0 empty frame");
        in_line_num = 12'd0;
        in_buf_ready = 1'b1;
        in_start = 1'b1;
        vs = valid_seen;
        d0 = done_count;
        check("t3_protect_idle", out_write_protect, 1'b0);
        tick();
        in_start = 1'b0;
        check("t3_protect_lock", out_write_protect, 1'b1);
        check("t3_busy_lock", out_busy, 1'b1);
        check("t3_done_lock", out_done, 1'b0);
        tick();
        check("t3_done_fin", out_done, 1'b1);
        check("t3_protect_fin", out_write_protect, 1'b1);
        tick();
        check("t3_protect_after", out_write_protect, 1'b0);
        check("t3_busy_after", out_busy, 1'b0);
        check("t3_no_valid", valid_seen - vs, 0);
        check("t3_done_count", done_count - d0, 1);
        check("t3_seg_count", out_seg_count, 0);
        in_buf_ready = 1'b0;

        // N=4 with random back-pressure, stall length capped at 10
        $display("[TB] N=4 with back-pressure");
        push_frame(4);
        in_line_num = 12'd4;
        in_buf_ready = 1'b1;
        in_tready = 1'b0;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        stall_chk = 1'b1;
        bc0 = beat_count;
        d0 = done_count;
        stall = 0;
        n = 0;
        while (done_count == d0 && n < 400) begin
            if (n < 8) in_tready = 1'b0;
            else if (stall >= 10) in_tready = 1'b1;
            else in_tready = 1'($urandom_range(0, 1));
            stall = in_tready ? 0 : stall + 1;
            tick();
            n++;
        end
        stall_chk = 1'b0;
        in_tready = 1'b1;
        in_buf_ready = 1'b0;
        check("t4_done_reached", (done_count == d0 + 1), 1'b1);
        check("t4_beats", beat_count - bc0, 4);
        check("t4_sb_empty", sb.size(), 0);
        check("t4_seg_count", done_seg, 4);

        // Buffer ready held low 50 cycles with a second start pulse in between
        $display("[TB] late buffer ready");
        push_frame(2);
        in_line_num = 12'd2;
        in_buf_ready = 1'b0;
        in_start = 1'b1;
        tick();
        prot_drop = 0;
        for (int i = 0; i < 50; i++) begin
            in_start = (i == 20);
            if (!out_write_protect || !out_busy) prot_drop++;
            tick();
        end
        in_start = 1'b0;
        check("t5_protect_held", prot_drop, 0);
        in_buf_ready = 1'b1;
        bc0 = beat_count;
        d0 = done_count;
        wait_done(100, d0);
        check("t5_beats", beat_count - bc0, 2);
        check("t5_sb_empty", sb.size(), 0);
        check("t5_seg_count", done_seg, 2);
        in_buf_ready = 1'b0;
        repeat (20) tick();
        check("t5_no_second_run", out_busy, 1'b0);
        check("t5_single_done", done_count - d0, 1);
        check("t5_protect_off", out_write_protect, 1'b0);

        // Largest frame: N = RAM_SIZE-1
        $display("[TB] N=4095 full-depth readout");
        push_frame(4095);
        in_line_num = 12'd4095;
        in_buf_ready = 1'b1;
        in_tready = 1'b1;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        max_addr = '0;
        bc0 = beat_count;
        d0 = done_count;
        wait_done(13000, d0);
        check("t6_beats", beat_count - bc0, 4095);
        check("t6_sb_empty", sb.size(), 0);
        check("t6_seg_count", done_seg, 4095);
        check("t6_final_addr", out_rd_addr, 4094);
        check("t6_max_addr", max_addr, 4094);
        in_buf_ready = 1'b0;
        tick();

        // Reset while beat 3 of an N=8 frame is waiting for tready
        $display("[TB] reset during SEND");
        push_frame(8);
        in_line_num = 12'd8;
        in_buf_ready = 1'b1;
        in_tready = 1'b1;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        bc0 = beat_count;
        n = 0;
        while (beat_count - bc0 < 3 && n < 100) begin
            tick();
            n++;
        end
        in_tready = 1'b0;
        n = 0;
        while (!out_tvalid && n < 20) begin
            tick();
            n++;
        end
        check("t1_beat3_valid", out_tvalid, 1'b1);
        check("t1_beat3_tdata", out_tdata, seg_of(12'd3));
        d0 = done_count;
        n_rst = 1'b0;
        #1;
        check("t1_rst_protect", out_write_protect, 1'b0);
        check("t1_rst_tvalid", out_tvalid, 1'b0);
        check("t1_rst_busy", out_busy, 1'b0);
        check("t1_rst_done", out_done, 1'b0);
        sb.delete();
        tick();
        n_rst = 1'b1;
        repeat (5) tick();
        check("t1_no_done", done_count - d0, 0);
        check("t1_idle_busy", out_busy, 1'b0);
        check("t1_seg_count", out_seg_count, 0);
        check("t1_rd_addr", out_rd_addr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
